// File: rtl/serial_rx_oversample.sv
// -----------------------------------------------------------------------------
// serial_rx_oversample
//   8N1 serial receiver, LSB first, 16x oversampling. An 8-bit prescaler
//   produces one oversample tick every DIV clocks. A 4-bit sample counter
//   locates the middle of the start bit (8 ticks in) and then every
//   16th tick after that for the data and stop bits.
//
// Parameters
//   DIV        clocks per oversample tick (1..255); bit period = 16*DIV clocks
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   data       last good received byte, held until the next good frame
//   valid      one-cycle pulse, data updated with a good frame
//   frame_err  one-cycle pulse, stop bit sampled low (data unchanged)
//   busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_rx_oversample #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] PLAST = 8'(DIV - 1);

  state_t     state;
  logic       sync1;
  logic       rx_s;
  logic       seen_high;
  logic [7:0] pcnt;
  logic [3:0] scnt;
  logic [2:0] bidx;
  logic [7:0] sh;
  logic       tick;

  // Oversample tick: last prescaler count while a frame is in progress.
  always_comb begin
    tick = 1'b0;
    if ((state != IDLE) && (pcnt == PLAST)) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // Two-flop synchronizer on rx; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Receiver FSM with prescaler, sample counter, shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seen_high <= 1'b0;
      pcnt      <= 8'd0;
      scnt      <= 4'd0;
      bidx      <= 3'd0;
      sh        <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      // Prescaler is parked at zero while idle so tick timing starts at START entry.
      if (state == IDLE) begin
        pcnt <= 8'd0;
      end else if (tick) begin
        pcnt <= 8'd0;
      end else begin
        pcnt <= pcnt + 8'd1;
      end

      if (tick) begin
        scnt <= scnt + 4'd1;
      end else begin
        scnt <= scnt;
      end

      case (state)
        IDLE: begin
          // seen_high only arms in IDLE, so a line left low after a bad
          // frame cannot look like a fresh falling edge.
          if (!rx_s && seen_high) begin
            state     <= START;
            busy      <= 1'b1;
            scnt      <= 4'd0;
            bidx      <= 3'd0;
            seen_high <= 1'b0;
          end else if (rx_s) begin
            seen_high <= 1'b1;
          end else begin
            seen_high <= seen_high;
          end
        end

        START: begin
          if (tick && (scnt == 4'd7)) begin
            scnt <= 4'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Glitch: line back high at mid start bit.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            state <= START;
          end
        end

        DATA: begin
          if (tick && (scnt == 4'd15)) begin
            sh   <= {rx_s, sh[7:1]};
            bidx <= bidx + 3'd1;
            scnt <= 4'd0;
            if (bidx == 3'd7) begin
              state <= STOP;
            end else begin
              state <= DATA;
            end
          end else begin
            state <= DATA;
          end
        end

        STOP: begin
          if (tick && (scnt == 4'd15)) begin
            if (rx_s) begin
              data  <= sh;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
            scnt  <= 4'd0;
          end else begin
            state <= STOP;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_oversample.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_oversample
//   Directed bench for serial_rx_oversample with DIV=4 (64 clocks per bit).
//   Each transmitted frame pushes its expected response (kind, byte, cycle)
//   onto a queue; an independent monitor pops and compares whenever the DUT
//   pulses valid or frame_err. Inputs change on the falling edge; outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_rx_oversample;

  localparam int DIV  = 4;
  localparam int BITC = 16 * DIV;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data;
  logic       prev_pulse;

  serial_rx_oversample #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (valid === 1'b1 && frame_err === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL both_pulses: valid=1 frame_err=1 required one at most (cycle %0d)", cyc);
      end
      if (valid === 1'b1 || frame_err === 1'b1) begin
        checks++;
        if (prev_pulse) begin
          errors++;
          $display("FAIL pulse_width: pulse high 2 cycles, required 1 (cycle %0d)", cyc);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data=0x%0h with nothing expected (cycle %0d)",
                   valid, frame_err, data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (frame_err !== e.is_err) begin
            errors++;
            $display("FAIL pulse_kind: frame_err=%0b required=%0b (cycle %0d)", frame_err, e.is_err, cyc);
          end
          checks++;
          if (data !== e.d) begin
            errors++;
            $display("FAIL pulse_data: actual=0x%0h required=0x%0h (cycle %0d)", data, e.d, cyc);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL pulse_time: actual cycle=%0d required=%0d", cyc, e.cyc);
          end
        end
      end
      prev_pulse <= (valid === 1'b1) || (frame_err === 1'b1);
    end
  end

  // Send one frame starting at the current falling edge. The next rising
  // edge is E0, so the outcome pulse is seen at cycle c0 + 3 + 152*DIV.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.is_err = ~stop_bit;
    e.d      = stop_bit ? b : model_data;
    e.cyc    = cyc + 3 + 152 * DIV;
    exp_q.push_back(e);
    if (stop_bit) model_data = b;
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0;
    int busy_seen;
    logic [7:0] c3;

    rst        = 1'b1;
    rx         = 1'b1;
    model_data = 8'h00;
    prev_pulse = 1'b0;

    // Reset for 3 cycles with the line idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_data", {24'd0, data}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    busy_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("idle_1000_busy", busy_seen, 32'd0);

    // Single byte with checked latency.
    send_frame(8'hA5, 1'b1);
    chk("a5_data_held", {24'd0, data}, 32'hA5);
    idle(100);

    // Back-to-back frames: fixed latency per frame implies 640-cycle spacing.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(200);

    // False start: 20 clock low pulse; busy from E2 until tick 8.
    c0 = cyc;
    rx = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) rx = 1'b1;
      if (cyc == c0 + 2) chk("fs_busy_before_e2", {31'd0, busy}, 32'd0);
      if (cyc == c0 + 3) chk("fs_busy_at_e2", {31'd0, busy}, 32'd1);
      if (cyc == c0 + 34) chk("fs_busy_before_tick8", {31'd0, busy}, 32'd1);
      if (cyc == c0 + 35) chk("fs_busy_after_tick8", {31'd0, busy}, 32'd0);
    end
    idle(200);

    // Framing error: 0x55 with stop low, line held low 300 more clocks.
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
    chk("ferr_no_restart", busy_seen, 32'd0);
    chk("ferr_data_kept", {24'd0, data}, 32'h3C);
    idle(100);
    send_frame(8'h81, 1'b1);
    idle(100);

    // Reset during data bit 4 of 0xC3, then 0x12.
    c3 = 8'hC3;
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      repeat (BITC) @(negedge clk);
    end
    rx = c3[4];
    repeat (BITC / 2) @(negedge clk);
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    chk("mid_rst_data", {24'd0, data}, 32'h00);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    idle(100);
    send_frame(8'h12, 1'b1);
    chk("final_data", {24'd0, data}, 32'h12);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_oversample.md
# serial_rx_oversample

Serial receiver for the serial communication link: 8N1 framing, LSB first, 16x oversampling. Sample ticks come from a built-in two-stage counter: an 8-bit prescaler feeding a 4-bit sample counter. It recovers bytes from the asynchronous `rx` line and presents each byte with a one-cycle valid strobe. It is the far end of the serial line, the counterpart that consumes what the link transmitter drives.

## Interface
- `DIV`, default 4: clocks per oversample tick; legal range 1..255; bit period = 16*DIV clocks.
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `data`  out  8  last received byte; holds until next frame completes.
- `valid`  out  1  one-cycle pulse: `data` updated with a good frame.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Input synchronizer: two flops on `rx`, both reset to 1. Output `rx_s`. A `seen_high` flag resets to 0 and sets once `rx_s`=1 has been registered.
- Prescaler `pcnt` (8b): held at 0 in IDLE. Otherwise counts 0..DIV-1 and wraps. `tick` = (pcnt==DIV-1) while not IDLE.
- Sample counter `scnt` (4b): cleared on every state entry. Increments on `tick` and wraps 15->0.
- Bit index `bidx` (3b), shift register `sh` (8b). On each data sample, shift right with `rx_s` into bit 7, so the LSB is received first.
- States:
  - IDLE: if `rx_s`=0 and `seen_high`=1 (falling edge), go to START; clear `pcnt`, `scnt`, `bidx`.
  - START: on `tick` with `scnt`=7 (mid start bit): if `rx_s`=0, go to DATA. Else this is a false start; go to IDLE with no output.
  - DATA: on `tick` with `scnt`=15, sample a bit and increment `bidx`. After the sample with `bidx`=7, go to STOP.
  - STOP: on `tick` with `scnt`=15, sample the stop bit.
    - Stop bit 1: `data`<=`sh`, pulse `valid`.
    - Stop bit 0: pulse `frame_err`; `data` unchanged.
    - Either case: go to IDLE.
- A line still low after a framing error does not retrigger. IDLE needs a new falling edge, and `seen_high` clears on entry to START.
- `valid` and `frame_err` are never high in the same cycle, and each is high for exactly one cycle.
- Reset at any point, including mid-frame, aborts the frame. Reset values: state IDLE, `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, `pcnt`=`scnt`=`bidx`=0, `sh`=0.

## Timing
- E0 is the first edge that registers `rx`=0 into sync stage 1.
- `rx_s` goes low after edge E1. START is entered at edge E2, and `busy` is high from E2.
- Tick n (n>=1) is active in the cycle before edge E2+n*DIV. Registered actions for that tick land at that edge.
- Start check: tick 8, so at E2+8*DIV.
- Data bit k (k=0..7) is sampled at E2+(8+16*(k+1))*DIV.
- Stop bit is sampled at E2+152*DIV. `valid` or `frame_err` is high in the following cycle, and `busy` drops at the same edge.
- Earliest next start detection: the cycle after the return to IDLE.
- Frame-to-frame: back-to-back frames with no idle gap beyond the stop bit are received. The sender must run within ±3% of 16*DIV clocks/bit.

## Test plan
- Reset: assert `rst` 3 cycles with `rx`=1, then release. Required: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state stays IDLE for 1000 cycles.
- Single byte, DIV=4: drive 0xA5 with 64-clock bits. Required: `valid` pulses once, exactly 2+152*4 cycles after E0; `data`=0xA5; `frame_err` never asserts.
- Back-to-back frames, DIV=4: drive 0x00, 0xFF, 0x3C with no gaps. Required: three `valid` pulses with data in order; pulse spacing 640 cycles.
- False start: pulse `rx` low for 20 clocks (DIV=4). Required: `busy` high, then low at tick 8; no `valid` or `frame_err`.
- Framing error: send 0x55 with the stop bit low and the line held low 300 clocks, then a good 0x81. Required: one `frame_err` pulse; `data` stays at its prior value; no restart while the line is low; 0x81 received with `valid`.
- Reset mid-frame: assert `rst` during data bit 4 of 0xC3, then send 0x12. Required: outputs cleared; no output for 0xC3; 0x12 received correctly.
